// File: rtl/dm_store_buffer.sv
// Data-memory store buffer: posts CPU stores into a small FIFO, forwards pending
// store bits to loads, and arbitrates the single-port SRAM with an external port.
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_ceb,
    input  logic                     cpu_web,
    input  logic [31:0]              cpu_bweb,
    input  logic [13:0]              cpu_a,
    input  logic [31:0]              cpu_in,
    output logic [31:0]              cpu_out,
    output logic                     sram_ceb,
    output logic                     sram_web,
    output logic [31:0]              sram_bweb,
    output logic [13:0]              sram_a,
    output logic [31:0]              sram_in,
    input  logic [31:0]              sram_out,
    input  logic                     ext_req,
    input  logic                     ext_we,
    input  logic [13:0]              ext_a,
    input  logic [31:0]              ext_in,
    output logic                     ext_gnt,
    output logic                     ext_rvalid,
    output logic [31:0]              ext_out,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] data;
        logic [DW-1:0] bweb;
    } entry_t;

    entry_t             entries [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [DW-1:0]      fwd_mask_q;
    logic [DW-1:0]      fwd_data_q;
    logic               ext_rvalid_q;

    logic               load;
    logic               store;
    logic               full;
    logic               pop;
    logic [DW-1:0]      fwd_mask_d;
    logic [DW-1:0]      fwd_data_d;
    logic [PTR_W-1:0]   idx;

    assign load  = !cpu_ceb && cpu_web;
    assign store = !cpu_ceb && !cpu_web;
    assign full  = (count_q == CNT_W'(DEPTH));

    // SRAM arbitration: load > forced drain > external > normal drain > idle
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_in   = '0;
        ext_gnt   = 1'b0;
        pop       = 1'b0;
        if (load) begin
            sram_ceb = 1'b0;
            sram_a   = cpu_a;
        end else if (full) begin
            pop       = 1'b1;
            sram_ceb  = 1'b0;
            sram_web  = 1'b0;
            sram_bweb = entries[head_q].bweb;
            sram_a    = entries[head_q].a;
            sram_in   = entries[head_q].data;
        end else if (ext_req) begin
            ext_gnt   = 1'b1;
            sram_ceb  = 1'b0;
            sram_web  = !ext_we;
            sram_bweb = ext_we ? '0 : '1;
            sram_a    = ext_a;
            sram_in   = ext_in;
        end else if (count_q != '0) begin
            pop       = 1'b1;
            sram_ceb  = 1'b0;
            sram_web  = 1'b0;
            sram_bweb = entries[head_q].bweb;
            sram_a    = entries[head_q].a;
            sram_in   = entries[head_q].data;
        end
    end

    // Walk oldest to newest so later matching entries override earlier bits
    always_comb begin
        fwd_mask_d = '0;
        fwd_data_d = '0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (entries[idx].a == cpu_a)) begin
                fwd_mask_d = fwd_mask_d | ~entries[idx].bweb;
                fwd_data_d = (fwd_data_d & entries[idx].bweb) |
                             (entries[idx].data & ~entries[idx].bweb);
            end
        end
        if (!load) begin
            fwd_mask_d = '0;
            fwd_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            fwd_mask_q   <= '0;
            fwd_data_q   <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            // pop clears first so a push into the same slot (full buffer) wins
            if (pop) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (store) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            case ({store, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            fwd_mask_q   <= fwd_mask_d;
            fwd_data_q   <= fwd_data_d;
            ext_rvalid_q <= ext_gnt && !ext_we;
        end
    end

    // Payload storage needs no reset; validity lives in valid_q
    always_ff @(posedge clk) begin
        if (store) begin
            entries[tail_q] <= '{a: cpu_a, data: cpu_in, bweb: cpu_bweb};
        end
    end

    assign cpu_out    = (sram_out & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);
    assign ext_rvalid = ext_rvalid_q;
    assign ext_out    = sram_out;
    assign sb_count   = count_q;
    assign sb_empty   = (count_q == '0);

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with a behavioural single-port SRAM model.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ceb, cpu_web;
    logic [31:0] cpu_bweb, cpu_in, cpu_out;
    logic [13:0] cpu_a;
    logic        sram_ceb, sram_web;
    logic [31:0] sram_bweb, sram_in, sram_out;
    logic [13:0] sram_a;
    logic        ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [13:0] ext_a;
    logic [31:0] ext_in, ext_out;
    logic [2:0]  sb_count;
    logic        sb_empty;

    logic [31:0] mem [0:16383];
    int          wr_count = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          wr_snap;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_ceb(cpu_ceb), .cpu_web(cpu_web), .cpu_bweb(cpu_bweb),
        .cpu_a(cpu_a), .cpu_in(cpu_in), .cpu_out(cpu_out),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
        .sram_a(sram_a), .sram_in(sram_in), .sram_out(sram_out),
        .ext_req(ext_req), .ext_we(ext_we), .ext_a(ext_a), .ext_in(ext_in),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_out(ext_out),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    // Single-port SRAM: bit-masked write, one-cycle read latency
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web)
                mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_in & ~sram_bweb);
            else
                sram_out <= mem[sram_a];
        end
    end

    always @(posedge clk) begin
        if (!sram_ceb && !sram_web) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_ceb = 1'b1; cpu_web = 1'b1; cpu_bweb = '1; cpu_a = '0; cpu_in = '0;
    endtask

    task automatic do_store(input logic [13:0] a, input logic [31:0] d, input logic [31:0] be);
        cpu_ceb = 1'b0; cpu_web = 1'b0; cpu_a = a; cpu_in = d; cpu_bweb = be;
    endtask

    task automatic do_load(input logic [13:0] a);
        cpu_ceb = 1'b0; cpu_web = 1'b1; cpu_a = a; cpu_in = '0; cpu_bweb = '1;
    endtask

    task automatic ext_write(input logic [13:0] a, input logic [31:0] d);
        ext_req = 1'b1; ext_we = 1'b1; ext_a = a; ext_in = d;
        #1 chk("ext_wr_gnt", 32'(ext_gnt), 32'd1);
        tick();
        ext_req = 1'b0; ext_we = 1'b0;
    endtask

    initial begin
        cpu_idle();
        ext_req = 1'b0; ext_we = 1'b0; ext_a = '0; ext_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_sram_ceb", 32'(sram_ceb), 32'd1);
        chk("rst_sram_web", 32'(sram_web), 32'd1);
        chk("rst_sram_bweb", sram_bweb, 32'hFFFF_FFFF);
        chk("rst_ext_gnt", 32'(ext_gnt), 32'd0);
        chk("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
        rst = 1'b0;
        tick();

        ext_write(14'h020, 32'h1122_3344);
        ext_write(14'h040, 32'hCAFE_F00D);

        // Posted store drains on the next idle cycle
        do_store(14'h010, 32'h1234_5678, 32'h0);
        #1 chk("st_cycle_idle", 32'(sram_ceb), 32'd1);
        tick();
        cpu_idle();
        #1;
        chk("drain_count", 32'(sb_count), 32'd1);
        chk("drain_ceb", 32'(sram_ceb), 32'd0);
        chk("drain_web", 32'(sram_web), 32'd0);
        chk("drain_a", 32'(sram_a), 32'h010);
        chk("drain_in", sram_in, 32'h1234_5678);
        chk("drain_bweb", sram_bweb, 32'h0);
        tick();
        chk("drain_empty", 32'(sb_empty), 32'd1);
        chk("drain_mem", mem[14'h010], 32'h1234_5678);

        // Partial-byte forwarding merged with SRAM data
        do_store(14'h020, 32'h0000_00AA, 32'hFFFF_FF00);
        tick();
        do_load(14'h020);
        #1;
        chk("ld_ceb", 32'(sram_ceb), 32'd0);
        chk("ld_web", 32'(sram_web), 32'd1);
        chk("ld_a", 32'(sram_a), 32'h020);
        chk("ld_count", 32'(sb_count), 32'd1);
        tick();
        cpu_idle();
        #1;
        chk("fwd_partial", cpu_out, 32'h1122_33AA);
        chk("fwd_count", 32'(sb_count), 32'd1);
        tick();
        chk("fwd_drained", 32'(sb_empty), 32'd1);
        chk("fwd_mem", mem[14'h020], 32'h1122_33AA);

        // Newest entry wins; ext reads hold off normal drains
        ext_req = 1'b1; ext_we = 1'b0; ext_a = 14'h100;
        do_store(14'h030, 32'hDEAD_BEEF, 32'h0);
        tick();
        do_store(14'h030, 32'h0000_5500, 32'hFFFF_00FF);
        tick();
        do_load(14'h030);
        #1 chk("newest_count", 32'(sb_count), 32'd2);
        tick();
        cpu_idle();
        #1 chk("fwd_newest", cpu_out, 32'hDEAD_55EF);
        ext_req = 1'b0;
        tick();
        tick();
        chk("newest_empty", 32'(sb_empty), 32'd1);
        chk("newest_mem", mem[14'h030], 32'hDEAD_55EF);

        // Fill, then forced drains with pointer wrap
        ext_req = 1'b1; ext_we = 1'b0; ext_a = 14'h100;
        for (int i = 0; i < 4; i++) begin
            do_store(14'(14'h200 + i), 32'hA000 + 32'(i), 32'h0);
            #1 chk("fill_gnt", 32'(ext_gnt), 32'd1);
            tick();
        end
        chk("fill_count", 32'(sb_count), 32'd4);
        for (int i = 4; i < 13; i++) begin
            do_store(14'(14'h200 + i), 32'hA000 + 32'(i), 32'h0);
            #1;
            chk("force_gnt", 32'(ext_gnt), 32'd0);
            chk("force_web", 32'(sram_web), 32'd0);
            chk("force_a", 32'(sram_a), 32'h200 + 32'(i - 4));
            tick();
            chk("force_count", 32'(sb_count), 32'd4);
        end
        cpu_idle();
        ext_req = 1'b0;
        repeat (4) tick();
        chk("wrap_empty", 32'(sb_empty), 32'd1);
        for (int i = 0; i < 13; i++)
            chk("wrap_mem", mem[14'(14'h200 + i)], 32'hA000 + 32'(i));

        // Reset mid-burst discards pending stores
        ext_req = 1'b1; ext_we = 1'b0; ext_a = 14'h100;
        for (int i = 0; i < 3; i++) begin
            do_store(14'(14'h300 + i), 32'hB000 + 32'(i), 32'h0);
            tick();
        end
        cpu_idle();
        ext_req = 1'b0;
        #1;
        chk("pre_rst_count", 32'(sb_count), 32'd3);
        wr_snap = wr_count;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(sb_count), 32'd0);
        chk("mid_rst_empty", 32'(sb_empty), 32'd1);
        chk("mid_rst_ceb", 32'(sram_ceb), 32'd1);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_writes", 32'(wr_count), 32'(wr_snap));
        chk("post_rst_empty", 32'(sb_empty), 32'd1);

        // External read, then external read losing to a CPU load
        ext_req = 1'b1; ext_we = 1'b0; ext_a = 14'h040;
        #1;
        chk("ext_rd_gnt", 32'(ext_gnt), 32'd1);
        chk("ext_rd_a", 32'(sram_a), 32'h040);
        tick();
        ext_req = 1'b0;
        #1;
        chk("ext_rvalid", 32'(ext_rvalid), 32'd1);
        chk("ext_out", ext_out, 32'hCAFE_F00D);
        tick();
        chk("ext_rvalid_drop", 32'(ext_rvalid), 32'd0);
        ext_req = 1'b1; ext_a = 14'h040;
        do_load(14'h020);
        #1;
        chk("ld_vs_ext_gnt", 32'(ext_gnt), 32'd0);
        chk("ld_vs_ext_a", 32'(sram_a), 32'h020);
        tick();
        cpu_idle();
        ext_req = 1'b0;
        #1;
        chk("ld_vs_ext_out", cpu_out, 32'h1122_33AA);
        chk("ld_vs_ext_rvalid", 32'(ext_rvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Data-memory store buffer and port arbiter between the CPU data-memory port (CEB/WEB/BWEB/A/IN/OUT) and the single-port data SRAM. CPU stores are posted into a DEPTH-entry FIFO, so a store never waits for the SRAM. Loads get priority and see pending stores through per-bit forwarding. A secondary external port (DMA/debug) shares the SRAM and only uses cycles not taken by CPU loads and forced drains.

## Interface
- DEPTH, 4: store-buffer entries; power of two, ≥2.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_ceb / cpu_web  in  1 / 1  CPU chip enable / write enable, both active low.
- cpu_bweb  in  32  per-bit write enable, active low (0 = write that bit).
- cpu_a  in  14  word address.
- cpu_in  in  32  store data.
- cpu_out  out  32  load data, valid the cycle after the load request.
- sram_ceb, sram_web, sram_bweb, sram_a, sram_in  out  1,1,32,14,32  SRAM request, same encoding as the CPU side.
- sram_out  in  32  SRAM read data, one cycle after a read request.
- ext_req / ext_we  in  1 / 1  external request / write (active high).
- ext_a / ext_in  in  14 / 32  external address / data (full-word writes).
- ext_gnt  out  1  external request served this cycle (combinational).
- ext_rvalid / ext_out  out  1 / 32  external read data, valid the cycle after a granted read.
- sb_count  out  $clog2(DEPTH)+1  occupied entries.
- sb_empty  out  1  sb_count == 0.

## Operation
- Entry format: {a[13:0], data[31:0], bweb[31:0]}. Circular FIFO with head/tail pointers that wrap modulo DEPTH, plus a count register.
- Request decode: load = !cpu_ceb & cpu_web; store = !cpu_ceb & !cpu_web.
- SRAM arbitration, highest priority first:
  1. CPU load: SRAM read at cpu_a.
  2. Forced drain: count == DEPTH; head entry is written.
  3. External request: ext_gnt = 1.
  4. Normal drain: count > 0; head entry is written.
  5. Idle: sram_ceb = 1.
- Idle SRAM outputs: sram_web = 1, sram_bweb = all 1s.
- ext_gnt = ext_req & !load & !(count == DEPTH).
- A store is always enqueued at the tail in its own cycle:
  - A store cycle is never a load cycle.
  - If the buffer is full, the same cycle performs a forced drain, so push and pop occur together and count stays DEPTH.
  - The CPU is never stalled.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- A new store cannot drain in the cycle it is pushed; the head is the oldest entry valid at the start of the cycle.
- Load forwarding, computed in the request cycle:
  - For each bit i, fwd_mask[i] = 1 if any valid entry has a == cpu_a and bweb[i] == 0.
  - fwd_data[i] comes from the newest such entry.
  - fwd_mask and fwd_data are registered.
  - Next cycle: cpu_out = (sram_out & ~fwd_mask) | (fwd_data & fwd_mask).
- On non-load cycles fwd_mask is registered as 0, so cpu_out passes sram_out through.
- External accesses get no forwarding. An external read of an address with a pending entry returns the SRAM contents. A later drain overwrites an external write to the same address. Software orders these using sb_empty.
- External reads register ext_rvalid = 1, and ext_out = sram_out in the following cycle.

## Timing
- Reset (async) values:
  - Registers: head = tail = count = 0, fwd_mask = 0, fwd_data = 0, ext_rvalid = 0. All entries are invalidated.
  - Outputs: sb_empty = 1, sb_count = 0.
  - With cpu_ceb = 1 and ext_req = 0: sram_ceb = 1, sram_web = 1, sram_bweb = all 1s, ext_gnt = 0.
- Reset mid-operation: pending entries are discarded and never written.
- SRAM request outputs and ext_gnt are combinational from inputs and current state. No added request latency.
- Latencies:
  - Load data: 1 cycle.
  - External read data: 1 cycle after grant.
  - A store reaches the SRAM ≥1 cycle after its request.

## Test plan
- Reset: assert rst mid-burst with count = 3 → immediately sb_count = 0, sb_empty = 1, sram_ceb = 1. No further SRAM writes after release.
- Store 0x12345678 to A = 0x010 with bweb = 0, then idle → next cycle: sram_ceb = 0, sram_web = 0, sram_a = 0x010, sram_in = 0x12345678; then sb_empty = 1.
- SRAM[0x020] = 0x11223344. Store data 0xAA, bweb = 0xFFFFFF00 to 0x020, then load 0x020 the next cycle → sram_a = 0x020 read, cpu_out = 0x112233AA, sb_count stays 1.
- Store 0xDEADBEEF (bweb = 0), then 0x00005500 (bweb = 0xFFFF00FF) to 0x030, with ext_req held so neither drains. Then load 0x030 → cpu_out = 0xDEAD55EF (newest wins).
- Hold ext_req = 1 (reads) and issue 4 stores → count = 4, ext_gnt = 1 during the first 4 cycles. A 5th store → forced drain of entry 0, ext_gnt = 0, count stays 4. Pointers wrap correctly over 8 further stores.
- External read at 0x040 with the SRAM idle → ext_gnt = 1; next cycle ext_rvalid = 1, ext_out = SRAM[0x040]. A simultaneous CPU load → ext_gnt = 0 and the load is served.
